time_display_scan: RTL and testbench
====================================

TIME_DISPLAY_SCAN -- requirements
Module: time_display_scan

Interface
REQ-001 Parameter: REFRESH_DIV, 100000, clk cycles per digit slot; legal values >= 2.
REQ-002 Parameter: LEAD_ZERO_BLANK, 1, when 1 a zero minutes-tens digit is blanked.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  reset is synchronous and active-low; state takes reset values on the rising clk edge while reset=0.
REQ-005 seconds_units  input  4  BCD seconds units from the seconds/minutes counter.
REQ-006 seconds_tens  input  3  seconds tens, 0-5.
REQ-007 minutes_units  input  4  BCD minutes units.
REQ-008 minutes_tens  input  3  minutes tens, 0-5.
REQ-009 anode  output  4  digit enables, active-low, one-hot-low; bit0 = seconds_units (rightmost), bit3 = minutes_tens.
REQ-010 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 dp  output  1  decimal point / colon, active-low, shown on digit 2 only.

Function
REQ-012 State: prescaler presc (0..REFRESH_DIV-1), digit index idx (0..3), 14-bit snapshot of the four digit inputs, colon_phase bit.
REQ-013 presc increments by 1 each cycle; at REFRESH_DIV-1 it wraps to 0 and idx advances by 1, wrapping 3->0.
REQ-014 Snapshot loads all four inputs on the edge where presc=REFRESH_DIV-1 and idx=3 (frame start); inputs are ignored at all other edges.
REQ-015 Input changes within a frame do not affect displayed values until the next frame start.
REQ-016 On a snapshot load, colon_phase toggles if the new seconds_units differs from the previous snapshot's seconds_units; otherwise it is held.
REQ-017 Ghost blanking: while presc=0, anode=4'b1111, seg=7'b1111111, dp=1.
REQ-018 While presc!=0, anode drives only bit idx low; seg shows the decoded snapshot digit selected by idx.
REQ-019 Decode (seg): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-020 A digit value >9 (4-bit fields) displays dash: seg=0111111.
REQ-021 If LEAD_ZERO_BLANK=1 and snapshot minutes_tens=0, then during idx=3 anode=4'b1111 and seg=7'b1111111.
REQ-022 dp=0 only when idx=2, presc!=0 and colon_phase=1; otherwise dp=1.
REQ-023 Outputs depend only on registered state; no combinational path from digit inputs to outputs.
REQ-024 Every frame lasts exactly 4*REFRESH_DIV cycles; each digit is active REFRESH_DIV-1 cycles per frame.

Reset
REQ-025 While reset=0 at an edge: presc=0, idx=0, snapshot=all zeros, colon_phase=0.
REQ-026 Resulting outputs after reset: anode=4'b1111, seg=7'b1111111, dp=1.
REQ-027 Reset asserted mid-frame overrides all counting and snapshot loads on that edge.
REQ-028 First frame after reset displays the zero snapshot; live inputs appear from the first frame start (cycle 4*REFRESH_DIV after release).

Verification (REFRESH_DIV=4)
REQ-029 Reset low 3 cycles then release, inputs 0 -> cycle 0 anode=1111; cycles 1-3 anode=1110, seg=1000000, dp=1; cycles 5-7 anode=1101.
REQ-030 Inputs mt=1, mu=2, st=3, su=4, LEAD_ZERO_BLANK=1 -> second frame: anode 1110 seg 0011001; 1101 seg 0110000; 1011 seg 0100100; 0111 seg 1111001.
REQ-031 Change su 4->7 at presc=2, idx=1 -> rest of frame still shows 4; next frame digit0 seg=1111000.
REQ-032 mt=0: LEAD_ZERO_BLANK=1 -> idx=3 slots anode=1111; LEAD_ZERO_BLANK=0 -> anode=0111, seg=1000000.
REQ-033 su=4'hC -> idx=0 slots seg=0111111; su change 4->5 across frame start -> colon_phase=1, dp=0 in idx=2 presc 1-3; next frame unchanged su keeps dp=0.
REQ-034 reset=0 for one cycle at presc=2, idx=1 -> next cycle all REQ-025/026 values, snapshot cleared, counting restarts from presc=0.

Source files
------------

// File: rtl/time_display_scan_if.sv
// Bus between the BCD time source and the 4-digit multiplexed 7-segment scanner.
interface time_display_scan_if;
  logic [3:0] seconds_units;
  logic [2:0] seconds_tens;
  logic [3:0] minutes_units;
  logic [2:0] minutes_tens;
  logic [3:0] anode;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output seconds_units, seconds_tens, minutes_units, minutes_tens,
    input  anode, seg, dp
  );
  modport slave (
    input  seconds_units, seconds_tens, minutes_units, minutes_tens,
    output anode, seg, dp
  );
endinterface

// File: rtl/time_display_scan.sv
// Time-multiplexed MM:SS scanner for a 4-digit common-anode 7-segment display.
// The digits are snapshotted once per frame so that no digit tears while the frame is displayed.
module time_display_scan #(
  parameter int REFRESH_DIV     = 100000,
  parameter bit LEAD_ZERO_BLANK = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  time_display_scan_if.slave bus
);
  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);

  typedef struct packed {
    logic [2:0] mt;
    logic [3:0] mu;
    logic [2:0] st;
    logic [3:0] su;
  } snap_t;

  logic [PW-1:0] presc;
  logic [1:0]    idx;
  snap_t         snap;
  logic          colon_phase;
  logic          slot_end, frame_start;

  assign slot_end    = (presc == PRESC_MAX);
  assign frame_start = slot_end && (idx == 2'd3);

  always_ff @(posedge clk) begin
    if (!reset) begin
      presc       <= '0;
      idx         <= '0;
      snap        <= '0;
      colon_phase <= 1'b0;
    end else begin
      presc <= slot_end ? '0 : presc + 1'b1;
      if (slot_end) idx <= idx + 2'd1;
      if (frame_start) begin
        snap <= '{mt: bus.minutes_tens, mu: bus.minutes_units,
                  st: bus.seconds_tens, su: bus.seconds_units};
        // The colon blinks at the seconds rate: it flips whenever a new second is captured.
        if (bus.seconds_units != snap.su) colon_phase <= ~colon_phase;
      end
    end
  end

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  logic [3:0] digit;
  logic       blank;

  always_comb begin
    digit = snap.su;
    case (idx)
      2'd0: digit = snap.su;
      2'd1: digit = {1'b0, snap.st};
      2'd2: digit = snap.mu;
      2'd3: digit = {1'b0, snap.mt};
    endcase
    // presc==0 is a dead slot between digits to hide ghosting while anodes switch.
    blank = (presc == '0) ||
            (LEAD_ZERO_BLANK && (idx == 2'd3) && (snap.mt == 3'd0));

    bus.anode = 4'b1111;
    bus.seg   = 7'b1111111;
    bus.dp    = 1'b1;
    if (!blank) begin
      bus.anode      = 4'b1111;
      bus.anode[idx] = 1'b0;
      bus.seg        = decode(digit);
    end
    if ((presc != '0) && (idx == 2'd2) && colon_phase) bus.dp = 1'b0;
  end
endmodule

// File: tb/tb_time_display_scan.sv
// Scoreboard bench: frame expectations are queued as stimulus is planned, then popped each cycle.
module tb_time_display_scan;
  localparam int R = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  time_display_scan_if bus_a ();
  time_display_scan_if bus_b ();

  time_display_scan #(.REFRESH_DIV(R), .LEAD_ZERO_BLANK(1'b1)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave));
  time_display_scan #(.REFRESH_DIV(R), .LEAD_ZERO_BLANK(1'b0)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave));

  typedef struct packed {
    logic [11:0] a;
    logic [11:0] b;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0: s = 7'b1000000; 4'd1: s = 7'b1111001; 4'd2: s = 7'b0100100;
      4'd3: s = 7'b0110000; 4'd4: s = 7'b0011001; 4'd5: s = 7'b0010010;
      4'd6: s = 7'b0000010; 4'd7: s = 7'b1111000; 4'd8: s = 7'b0000000;
      4'd9: s = 7'b0010000; default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  task automatic drive(input logic [3:0] su, input logic [2:0] st,
                       input logic [3:0] mu, input logic [2:0] mt);
    bus_a.seconds_units = su; bus_a.seconds_tens = st;
    bus_a.minutes_units = mu; bus_a.minutes_tens = mt;
    bus_b.seconds_units = su; bus_b.seconds_tens = st;
    bus_b.minutes_units = mu; bus_b.minutes_tens = mt;
  endtask

  // Queue one full frame of expected {anode,seg,dp} for both blanking variants.
  task automatic push_frame(input logic [3:0] su, st, mu, mt, input logic colon);
    logic [3:0] dig [4];
    logic [3:0] an;
    logic [6:0] sg;
    logic       d;
    exp_t       e;
    dig[0] = su; dig[1] = st; dig[2] = mu; dig[3] = mt;
    for (int i = 0; i < 4; i++) begin
      for (int p = 0; p < R; p++) begin
        if (p == 0) begin
          e.a = 12'b1111_1111111_1;
          e.b = 12'b1111_1111111_1;
        end else begin
          an = 4'b1111; an[i] = 1'b0;
          sg = seg_of(dig[i]);
          d  = !(i == 2 && colon);
          e.b = {an, sg, d};
          e.a = (i == 3 && mt == 4'd0) ? 12'b1111_1111111_1 : {an, sg, d};
        end
        q.push_back(e);
      end
    end
  endtask

  task automatic run(input int n, input string tag);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL %s: scoreboard empty at step %0d", tag, k);
      end else begin
        e = q.pop_front();
        checks++;
        assert ({bus_a.anode, bus_a.seg, bus_a.dp} === e.a) else begin
          errors++;
          $error("FAIL %s lzb1 step %0d: got %b_%b_%b exp %b_%b_%b", tag, k,
                 bus_a.anode, bus_a.seg, bus_a.dp, e.a[11:8], e.a[7:1], e.a[0]);
        end
        checks++;
        assert ({bus_b.anode, bus_b.seg, bus_b.dp} === e.b) else begin
          errors++;
          $error("FAIL %s lzb0 step %0d: got %b_%b_%b exp %b_%b_%b", tag, k,
                 bus_b.anode, bus_b.seg, bus_b.dp, e.b[11:8], e.b[7:1], e.b[0]);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset = 1'b0;
    drive(4'd0, 3'd0, 4'd0, 3'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    // Frame 0: zero snapshot; live inputs applied but not shown yet.
    drive(4'd4, 3'd3, 4'd2, 3'd1);
    push_frame(4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    run(16, "reset_frame");

    // Frame 1: 12:34, su changed 0->4 so colon on. su changes mid-frame at presc=2 idx=1.
    push_frame(4'd4, 4'd3, 4'd2, 4'd1, 1'b1);
    run(6, "frame1_head");
    drive(4'd7, 3'd3, 4'd2, 3'd1);
    run(10, "frame1_tail");

    // Frame 2: 12:37 picked up, colon toggles back off.
    drive(4'hC, 3'd3, 4'd2, 3'd0);
    push_frame(4'd7, 4'd3, 4'd2, 4'd1, 1'b0);
    run(16, "frame2");

    // Frame 3: dash on digit 0, zero minutes tens blanked only when enabled.
    drive(4'd4, 3'd3, 4'd2, 3'd0);
    push_frame(4'hC, 4'd3, 4'd2, 4'd0, 1'b1);
    run(16, "frame3_dash");

    drive(4'd5, 3'd3, 4'd2, 3'd0);
    push_frame(4'd4, 4'd3, 4'd2, 4'd0, 1'b0);
    run(16, "frame4");
    push_frame(4'd5, 4'd3, 4'd2, 4'd0, 1'b1);
    run(16, "frame5_colon");
    push_frame(4'd5, 4'd3, 4'd2, 4'd0, 1'b1);
    run(16, "frame6_hold");

    // Mid-frame reset at presc=2 idx=1.
    push_frame(4'd5, 4'd3, 4'd2, 4'd0, 1'b1);
    run(6, "frame7_head");
    q.delete();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    push_frame(4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    run(16, "post_reset");
    push_frame(4'd5, 4'd3, 4'd2, 4'd0, 1'b1);
    run(16, "post_reset_live");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end
endmodule
